uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
- UART TX: serialises a parallel byte onto `Tx` as a standard 8N1 frame: start bit 0, DATA_BITS data bits LSB first, stop bit 1.
- Bit timing is paced by the shared 16x oversampling `Tick` from the baud rate generator, the same tick that drives the receiver.
- Sits between the host/FIFO side (`TxStart`/`TxData` handshake) and the serial line. Pairs with the receiver for loopback.

Parameters:
- DATA_BITS, 8: data bits per frame (1..16).
- STOP_BIT_TICKS, 16: Ticks per bit period. Applies to start, data, stop (and parity, if enabled) bits.

Ports:
- Clock  input  1  system clock (50 MHz)
- ResetN  input  1  asynchronous active-low reset
- Tick  input  1  one-Clock-wide baud tick, 16x bit rate
- TxStart  input  1  request to send; sampled only in IDLE
- TxData  input  DATA_BITS  byte to send; captured on acceptance
- Tx  output  1  serial line, registered, idles high
- TxBusy  output  1  high while a frame is in progress (state != IDLE)
- TxDone  output  1  one-Clock pulse at end of stop bit

Behaviour:
- Reset (asynchronous, ResetN=0):
  - state=IDLE, Tx=1, TxBusy=0, TxDone=0.
  - Counters and shift register cleared.
  - Reset mid-frame aborts immediately; line returns high with no glitch low.
- Internal state:
  - Tick counter: $clog2(STOP_BIT_TICKS) bits.
  - Bit counter: $clog2(DATA_BITS) bits (min 1).
  - Shift register: DATA_BITS wide.
- Tx is a flop loaded with the next-state line value. No combinational path to the pin.
- IDLE:
  - Tx=1; Tick ignored.
  - On a Clock edge with TxStart=1: capture TxData into the shift register, clear tick counter, go START.
  - Tx=0 and TxBusy=1 from that same edge (zero-cycle latency from acceptance).
- START:
  - Tx=0. Each Tick increments the tick counter.
  - On the Tick where counter==STOP_BIT_TICKS-1: clear counter, clear bit counter, go DATA. Tx takes shift[0] on that edge.
- DATA:
  - Tx=shift[0].
  - On the Tick where counter==STOP_BIT_TICKS-1: clear counter, shift right (zero fill).
  - If bit counter==DATA_BITS-1, go STOP (Tx=1); else increment bit counter.
- STOP:
  - Tx=1.
  - On the Tick where counter==STOP_BIT_TICKS-1: go IDLE and pulse TxDone=1 for exactly one Clock.
- Frame length: exactly (2+DATA_BITS)*STOP_BIT_TICKS Ticks from acceptance to TxDone. Each bit lasts exactly STOP_BIT_TICKS Ticks.
- Non-Tick cycles: no counter change and no state change outside IDLE.
- TxStart while TxBusy=1: ignored. TxData changes during a frame have no effect.
- Back-to-back frames:
  - TxStart=1 in the cycle TxDone=1 (state IDLE) is accepted. Next start bit begins the following edge.
  - Minimum idle high between frames is one Clock beyond the stop bit.
- Tick coincident with acceptance: that Tick is not counted; the start bit still lasts STOP_BIT_TICKS full Ticks.
- Illegal state encoding: return to IDLE with Tx=1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP, lasting STOP_BIT_TICKS Ticks.
  - Tx = XOR of the captured data bits (even parity); with parameter PARITY_ODD=1 (default 0), the inverted value.
  - Parity is computed from the value captured at acceptance, not the shifted register.
  - Frame becomes (3+DATA_BITS)*STOP_BIT_TICKS Ticks.
- Undefined: no PARITY state; PARITY_ODD parameter absent; 8N1 framing only.

Test Plan:
- Reset: hold ResetN=0 mid-frame (after 40 Ticks of sending 0x00) -> Tx=1, TxBusy=0, TxDone=0 asynchronously; after release, line idles high, no TxDone.
- Basic frame: Tick 1-in-4 Clocks, TxStart pulse with TxData=0x55 -> Tx holds each level 64 Clocks in sequence 0,1,0,1,0,1,0,1,0,1; TxDone one Clock at Tick 160; received by loopback receiver as RxData=0x55.
- Ignore while busy: TxStart with 0xA3 mid-frame of 0x0F -> line carries only 0x0F (0, 1,1,1,1,0,0,0,0, 1); no second frame.
- Back-to-back: TxStart held high continuously with TxData=0xFF then 0x00 -> two frames, second start bit one Clock after TxDone; TxDone pulses exactly twice.
- Tick/start coincidence: TxStart and Tick in the same cycle -> start bit lasts exactly 16 subsequent Ticks.
- UART_TX_PARITY_EN, PARITY_ODD=0, TxData=0x07 -> parity bit 1 after bit 7; TxData=0x55 -> parity 0; TxDone at Tick 176.

Source files
------------

// File: rtl/uart_transmitter.sv
// UART transmitter: serialises TxData as start, DATA_BITS data (LSB first), [parity], stop; paced by 16x Tick.
// Latency: Tx drops low and TxBusy rises on the accepting edge; frame lasts (2+DATA_BITS)*STOP_BIT_TICKS Ticks (+1 bit with UART_TX_PARITY_EN).
// Backpressure: TxStart is honoured only while idle and ignored while TxBusy; TxDone pulses one Clock at the end of the stop bit.
module uart_transmitter #(
    parameter int DATA_BITS      = 8,
    parameter int STOP_BIT_TICKS = 16
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD     = 1'b0
`endif
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    input  logic                 Tick,
    input  logic                 TxStart,
    input  logic [DATA_BITS-1:0] TxData,
    output logic                 Tx,
    output logic                 TxBusy,
    output logic                 TxDone
);

    localparam int TW = (STOP_BIT_TICKS > 1) ? $clog2(STOP_BIT_TICKS) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(STOP_BIT_TICKS - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   bit_end;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    // A bit period ends on the Tick that sees the counter at its last value.
    assign bit_end = Tick && (tick_q == LAST_TICK);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (TxStart) begin
                    shift_d = TxData;
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = ST_START;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^TxData) ^ PARITY_ODD;
`endif
                end
            end
            ST_START: begin
                if (bit_end) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else if (Tick) begin
                    tick_d = tick_q + TW'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    tick_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else if (Tick) begin
                    tick_d = tick_q + TW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    tick_d  = '0;
                    state_d = ST_STOP;
                end else if (Tick) begin
                    tick_d = tick_q + TW'(1);
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    tick_d  = '0;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (Tick) begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tick_d  = '0;
                bit_d   = '0;
                shift_d = '0;
            end
        endcase
    end

    // The pin flop is loaded with the level of the state being entered, so
    // Tx never depends combinationally on inputs.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_q;
`endif
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign Tx     = tx_q;
    assign TxBusy = busy_q;
    assign TxDone = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: Tick every 4th Clock, frames checked at every bit boundary.
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int TPB = 16;

    logic       Clock = 1'b0;
    logic       ResetN = 1'b0;
    logic       Tick = 1'b0;
    logic       TxStart = 1'b0;
    logic [7:0] TxData = 8'h00;
    logic       Tx;
    logic       TxBusy;
    logic       TxDone;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;

    uart_transmitter #(
        .DATA_BITS      (8),
        .STOP_BIT_TICKS (TPB)
    ) dut (
        .Clock   (Clock),
        .ResetN  (ResetN),
        .Tick    (Tick),
        .TxStart (TxStart),
        .TxData  (TxData),
        .Tx      (Tx),
        .TxBusy  (TxBusy),
        .TxDone  (TxDone)
    );

    initial forever #10 Clock = ~Clock;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one Clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge Clock);
        #1;
        cyc++;
        if (TxDone) done_cnt++;
        Tick = ((cyc % 4) == 0);
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Sends d and checks the line at the first and last Tick of every bit.
    task automatic run_frame(input logic [7:0] d, input string tag, input bit keep_start,
                             input logic [7:0] next_dat, input int inj_at);
        int   ticks = 0;
        int   guard = 0;
        int   early = 0;
        logic tw;
        TxData  = d;
        TxStart = 1'b1;
        step();
        chk({tag, "_accept_tx"}, Tx, 1'b0);
        chk({tag, "_accept_busy"}, TxBusy, 1'b1);
        if (!keep_start) TxStart = 1'b0;
        TxData = next_dat;
        while (ticks < NB*TPB && guard < NB*TPB*4 + 40) begin
            tw = Tick;
            step();
            guard++;
            if (TxStart && !keep_start) TxStart = 1'b0;
            if (TxDone && ticks < NB*TPB - 1) early++;
            if (tw) begin
                ticks++;
                if (ticks == inj_at) begin
                    TxStart = 1'b1;
                    TxData  = 8'hA3;
                end
                if (ticks < NB*TPB) begin
                    if (ticks % TPB == TPB-1)
                        chk($sformatf("%s_bit%0d_end", tag, ticks/TPB), Tx, exp_bit(d, ticks/TPB));
                    if (ticks % TPB == 0)
                        chk($sformatf("%s_bit%0d_beg", tag, ticks/TPB), Tx, exp_bit(d, ticks/TPB));
                end
            end
        end
        chk({tag, "_tick_count"}, ticks, NB*TPB);
        chk({tag, "_done"}, TxDone, 1'b1);
        chk({tag, "_done_early"}, early, 0);
        chk({tag, "_busy_end"}, TxBusy, 1'b0);
        chk({tag, "_idle_tx"}, Tx, 1'b1);
    endtask

    task automatic idle_check(input string tag, input int n);
        int lows = 0;
        int dones = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (!Tx) lows++;
            if (TxDone) dones++;
        end
        chk({tag, "_idle_lows"}, lows, 0);
        chk({tag, "_idle_dones"}, dones, 0);
    endtask

    initial begin
        int base;
        int t;
        int g;
        ResetN = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("reset_tx", Tx, 1'b1);
        chk("reset_busy", TxBusy, 1'b0);
        chk("reset_done", TxDone, 1'b0);
        ResetN = 1'b1;
        idle_check("post_reset", 20);

        // Basic frame, acceptance edge without a Tick.
        while (Tick) step();
        run_frame(8'h55, "basic", 1'b0, 8'h55, 0);
        step();
        chk("basic_done_single", TxDone, 1'b0);
        idle_check("basic", 20);

        // Request with 0xA3 in the middle of a 0x0F frame must be dropped.
        while (Tick) step();
        base = done_cnt;
        run_frame(8'h0F, "busy", 1'b0, 8'h0F, 40);
        idle_check("busy", 200);
        chk("busy_done_pulses", done_cnt - base, 1);

        // TxStart held high: second frame accepted in the TxDone cycle.
        while (Tick) step();
        base = done_cnt;
        run_frame(8'hFF, "b2b1", 1'b1, 8'h00, 0);
        run_frame(8'h00, "b2b2", 1'b0, 8'h00, 0);
        idle_check("b2b", 100);
        chk("b2b_done_pulses", done_cnt - base, 2);

        // Tick in the acceptance cycle must not be counted.
        while (!Tick) step();
        run_frame(8'hC3, "coin", 1'b0, 8'hC3, 0);
        idle_check("coin", 20);

`ifdef UART_TX_PARITY_EN
        while (Tick) step();
        run_frame(8'h07, "par07", 1'b0, 8'h07, 0);
        idle_check("par07", 10);
        run_frame(8'h55, "par55", 1'b0, 8'h55, 0);
        idle_check("par55", 10);
`endif

        // Reset after 40 Ticks of a 0x00 frame: line must go high at once.
        TxData  = 8'h00;
        TxStart = 1'b1;
        step();
        TxStart = 1'b0;
        t = 0;
        g = 0;
        while (t < 40 && g < 400) begin
            if (Tick) t++;
            step();
            g++;
        end
        chk("rst_mid_ticks", t, 40);
        chk("rst_mid_tx_low", Tx, 1'b0);
        #2;
        ResetN = 1'b0;
        #1;
        chk("rst_async_tx", Tx, 1'b1);
        chk("rst_async_busy", TxBusy, 1'b0);
        chk("rst_async_done", TxDone, 1'b0);
        for (int i = 0; i < 3; i++) step();
        ResetN = 1'b1;
        idle_check("rst_release", 100);
        chk("rst_release_busy", TxBusy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
